// File: rtl/complete_stage_pkg.sv
// Shared types and constants for the complete/retire stage: ROB row layout,
// ROB depth and the store opcode that marks an entry as a silent retiree.
package p;

    localparam int ROB_DEPTH = 16;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef struct packed {
        logic        v;
        logic        instr_type;  // 1 = store, retires without writeback
        logic [5:0]  phy_reg;
        logic [31:0] result;
        logic [5:0]  old_phy;
        logic        comp;
    } rob_row;

    function automatic logic is_store(input logic [6:0] opc);
        return opc == OPC_STORE;
    endfunction

endpackage

// File: rtl/complete_stage_retire_select.sv
// Retire selection: picks zero, one or two in-order retirees starting at the
// ROB head. The second entry may only go if the head goes in the same cycle.
module rob_retire_select (
    input  logic       head_v,
    input  logic       head_comp,
    input  logic       next_v,
    input  logic       next_comp,
    output logic       ret_0,
    output logic       ret_1,
    output logic [1:0] n_ret
);

    // In-order retire decision for head and head+1
    always_comb begin
        ret_0 = head_v & head_comp;
        ret_1 = ret_0 & next_v & next_comp;
        n_ret = {1'b0, ret_0} + {1'b0, ret_1};
    end

endmodule

// File: rtl/complete_stage.sv
// Complete/retire stage with a 16-entry reorder buffer. Records up to three
// FU results per cycle, broadcasts them to the reservation stations and
// retires up to two instructions per cycle in program order.
// Build option: COMPLETE_FORWARD_EN enables the result broadcast outputs;
// without it forward_flag_K, dest_R_K and forwarded_data_K stay at 0.
module complete_stage
    import p::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_flag_ci,
    output logic        en_flag_co,
    input  logic [31:0] result_c1,
    input  logic [31:0] result_c2,
    input  logic [31:0] result_c3,
    input  logic [5:0]  result_dest_c1,
    input  logic [5:0]  result_dest_c2,
    input  logic [5:0]  result_dest_c3,
    input  logic        result_valid_c1,
    input  logic        result_valid_c2,
    input  logic        result_valid_c3,
    input  logic [3:0]  result_ROB_c1,
    input  logic [3:0]  result_ROB_c2,
    input  logic [3:0]  result_ROB_c3,
    input  logic [1:0]  result_FU_c1,
    input  logic [1:0]  result_FU_c2,
    input  logic [1:0]  result_FU_c3,
    input  logic        update_rob,
    input  logic [5:0]  rob_p_reg_1,
    input  logic [5:0]  rob_p_reg_2,
    input  logic [6:0]  rob_opcode_1,
    input  logic [6:0]  rob_opcode_2,
    input  logic [5:0]  o_rob_p_reg_1,
    input  logic [5:0]  o_rob_p_reg_2,
    input  logic [5:0]  pd_1_ci,
    output logic        forward_flag_1,
    output logic        forward_flag_2,
    output logic        forward_flag_3,
    output logic [5:0]  dest_R_1,
    output logic [5:0]  dest_R_2,
    output logic [5:0]  dest_R_3,
    output logic [31:0] forwarded_data_1,
    output logic [31:0] forwarded_data_2,
    output logic [31:0] forwarded_data_3,
    output logic        retire_flag_1,
    output logic        retire_flag_2,
    output logic [5:0]  retire_index_1,
    output logic [5:0]  retire_index_2,
    output logic [31:0] retire_result_1,
    output logic [31:0] retire_result_2,
    output logic [5:0]  fp_ind_1,
    output logic [5:0]  fp_ind_2,
    output logic        pr_flag
);

    localparam logic [4:0] ROB_FULL = 5'd16;

    // Channel inputs gathered into arrays; index 0 is channel 1 (highest priority)
    logic [31:0] res_c [3];
    logic        vld_c [3];
    logic [3:0]  idx_c [3];

    assign res_c[0] = result_c1;
    assign res_c[1] = result_c2;
    assign res_c[2] = result_c3;
    assign vld_c[0] = result_valid_c1;
    assign vld_c[1] = result_valid_c2;
    assign vld_c[2] = result_valid_c3;
    assign idx_c[0] = result_ROB_c1;
    assign idx_c[1] = result_ROB_c2;
    assign idx_c[2] = result_ROB_c3;

    // FU id and the debug tap carry no function here
    logic unused_ok;
    assign unused_ok = ^{result_FU_c1, result_FU_c2, result_FU_c3, pd_1_ci,
                         result_dest_c1, result_dest_c2, result_dest_c3};

    // ROB storage and pointers
    rob_row     rob_q [ROB_DEPTH];
    rob_row     rob_d [ROB_DEPTH];
    logic [3:0] head_q, head_d;
    logic [3:0] tail_q, tail_d;
    logic [4:0] count_q, count_d;

    // Registered outputs
    logic        en_flag_q, en_flag_d;
    logic        ff_q [3];
    logic        ff_d [3];
    logic [5:0]  dr_q [3];
    logic [5:0]  dr_d [3];
    logic [31:0] fd_q [3];
    logic [31:0] fd_d [3];
    logic        rf_q [2];
    logic        rf_d [2];
    logic [5:0]  ri_q [2];
    logic [5:0]  ri_d [2];
    logic [31:0] rr_q [2];
    logic [31:0] rr_d [2];
    logic [5:0]  fp_q [2];
    logic [5:0]  fp_d [2];
    logic        pr_q, pr_d;

    logic       ret_0, ret_1;
    logic [1:0] n_ret;
    logic [3:0] next_idx;
    logic       take_1, take_2;
    logic [3:0] slot_2;
    logic [1:0] n_alloc;

    assign next_idx = head_q + 4'd1;

    rob_retire_select u_retire_select (
        .head_v    (rob_q[head_q].v),
        .head_comp (rob_q[head_q].comp),
        .next_v    (rob_q[next_idx].v),
        .next_comp (rob_q[next_idx].comp),
        .ret_0     (ret_0),
        .ret_1     (ret_1),
        .n_ret     (n_ret)
    );

    // Allocation acceptance; the full check uses the pre-retire count
    always_comb begin
        take_1  = update_rob && (rob_opcode_1 != 7'd0) && (count_q < ROB_FULL);
        take_2  = update_rob && (rob_opcode_2 != 7'd0) &&
                  ((count_q + {4'd0, take_1}) < ROB_FULL);
        slot_2  = take_1 ? (tail_q + 4'd1) : tail_q;
        n_alloc = {1'b0, take_1} + {1'b0, take_2};
    end

    // ROB next state: completions (channel 1 applied last so it wins), retire clears, allocation
    always_comb begin
        rob_d = rob_q;
        for (int k = 2; k >= 0; k--) begin
            if (vld_c[k] && rob_q[idx_c[k]].v) begin
                rob_d[idx_c[k]].result = res_c[k];
                rob_d[idx_c[k]].comp   = 1'b1;
            end
        end
        if (ret_0) begin
            rob_d[head_q].v    = 1'b0;
            rob_d[head_q].comp = 1'b0;
        end
        if (ret_1) begin
            rob_d[next_idx].v    = 1'b0;
            rob_d[next_idx].comp = 1'b0;
        end
        if (take_1) begin
            rob_d[tail_q] = '{v: 1'b1, instr_type: is_store(rob_opcode_1), phy_reg: rob_p_reg_1,
                              result: 32'd0, old_phy: o_rob_p_reg_1, comp: 1'b0};
        end
        if (take_2) begin
            rob_d[slot_2] = '{v: 1'b1, instr_type: is_store(rob_opcode_2), phy_reg: rob_p_reg_2,
                              result: 32'd0, old_phy: o_rob_p_reg_2, comp: 1'b0};
        end
    end

    // Pointer and occupancy update; 4-bit pointers wrap 15 -> 0 naturally
    always_comb begin
        head_d  = head_q + {2'd0, n_ret};
        tail_d  = tail_q + {2'd0, n_alloc};
        count_d = count_q + {3'd0, n_alloc} - {3'd0, n_ret};
    end

    // Retire outputs: stores free their entry without writeback or free-list return
    always_comb begin
        rf_d[0] = ret_0 && !rob_q[head_q].instr_type;
        rf_d[1] = ret_1 && !rob_q[next_idx].instr_type;
        ri_d[0] = rf_d[0] ? rob_q[head_q].phy_reg   : 6'd0;
        ri_d[1] = rf_d[1] ? rob_q[next_idx].phy_reg : 6'd0;
        rr_d[0] = rf_d[0] ? rob_q[head_q].result    : 32'd0;
        rr_d[1] = rf_d[1] ? rob_q[next_idx].result  : 32'd0;
        fp_d[0] = rf_d[0] ? rob_q[head_q].old_phy   : 6'd0;
        fp_d[1] = rf_d[1] ? rob_q[next_idx].old_phy : 6'd0;
    end

    // Result broadcast; data outputs hold their last value while a channel is idle
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            ff_d[k] = 1'b0;
            dr_d[k] = 6'd0;
            fd_d[k] = 32'd0;
        end
`ifdef COMPLETE_FORWARD_EN
        ff_d[0] = vld_c[0];
        ff_d[1] = vld_c[1];
        ff_d[2] = vld_c[2];
        dr_d[0] = vld_c[0] ? result_dest_c1 : dr_q[0];
        dr_d[1] = vld_c[1] ? result_dest_c2 : dr_q[1];
        dr_d[2] = vld_c[2] ? result_dest_c3 : dr_q[2];
        for (int k = 0; k < 3; k++) begin
            fd_d[k] = vld_c[k] ? res_c[k] : fd_q[k];
        end
`endif
    end

    // Pipeline-valid copy and drained pulse (ROB emptied by retirement while dispatch is idle)
    always_comb begin
        en_flag_d = en_flag_ci;
        pr_d      = (n_ret != 2'd0) && (count_d == 5'd0) && !en_flag_ci;
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rob_q[i] <= '0;
            end
            head_q    <= 4'd0;
            tail_q    <= 4'd0;
            count_q   <= 5'd0;
            en_flag_q <= 1'b0;
            pr_q      <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                ff_q[k] <= 1'b0;
                dr_q[k] <= 6'd0;
                fd_q[k] <= 32'd0;
            end
            for (int j = 0; j < 2; j++) begin
                rf_q[j] <= 1'b0;
                ri_q[j] <= 6'd0;
                rr_q[j] <= 32'd0;
                fp_q[j] <= 6'd0;
            end
        end else begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rob_q[i] <= rob_d[i];
            end
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            en_flag_q <= en_flag_d;
            pr_q      <= pr_d;
            for (int k = 0; k < 3; k++) begin
                ff_q[k] <= ff_d[k];
                dr_q[k] <= dr_d[k];
                fd_q[k] <= fd_d[k];
            end
            for (int j = 0; j < 2; j++) begin
                rf_q[j] <= rf_d[j];
                ri_q[j] <= ri_d[j];
                rr_q[j] <= rr_d[j];
                fp_q[j] <= fp_d[j];
            end
        end
    end

    assign en_flag_co       = en_flag_q;
    assign forward_flag_1   = ff_q[0];
    assign forward_flag_2   = ff_q[1];
    assign forward_flag_3   = ff_q[2];
    assign dest_R_1         = dr_q[0];
    assign dest_R_2         = dr_q[1];
    assign dest_R_3         = dr_q[2];
    assign forwarded_data_1 = fd_q[0];
    assign forwarded_data_2 = fd_q[1];
    assign forwarded_data_3 = fd_q[2];
    assign retire_flag_1    = rf_q[0];
    assign retire_flag_2    = rf_q[1];
    assign retire_index_1   = ri_q[0];
    assign retire_index_2   = ri_q[1];
    assign retire_result_1  = rr_q[0];
    assign retire_result_2  = rr_q[1];
    assign fp_ind_1         = fp_q[0];
    assign fp_ind_2         = fp_q[1];
    assign pr_flag          = pr_q;

endmodule

// File: tb/tb_complete_stage.sv
// Testbench for complete_stage: directed scenarios followed by random traffic.
// The reference model keeps the ROB as an in-order queue of in-flight
// instructions; each cycle it predicts the full registered output vector and
// pushes it into a queue that the negedge monitor pops and compares.
module tb_complete_stage;

    localparam logic [6:0] OP_ALU = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_ST  = 7'b0100011;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        en_ci;
    logic [31:0] res_in [1:3];
    logic [5:0]  dst_in [1:3];
    logic        vld_in [1:3];
    logic [3:0]  rob_in [1:3];
    logic [1:0]  fu_in  [1:3];
    logic        upd;
    logic [5:0]  preg1, preg2, old1, old2, pd;
    logic [6:0]  op1, op2;

    logic             en_co;
    logic [3:1]       ff_o;
    logic [3:1][5:0]  dr_o;
    logic [3:1][31:0] fd_o;
    logic [2:1]       rf_o;
    logic [2:1][5:0]  ri_o;
    logic [2:1][31:0] rr_o;
    logic [2:1][5:0]  fp_o;
    logic             pr_o;

    complete_stage dut (
        .clk(clk), .rst_n(rst_n), .en_flag_ci(en_ci), .en_flag_co(en_co),
        .result_c1(res_in[1]), .result_c2(res_in[2]), .result_c3(res_in[3]),
        .result_dest_c1(dst_in[1]), .result_dest_c2(dst_in[2]), .result_dest_c3(dst_in[3]),
        .result_valid_c1(vld_in[1]), .result_valid_c2(vld_in[2]), .result_valid_c3(vld_in[3]),
        .result_ROB_c1(rob_in[1]), .result_ROB_c2(rob_in[2]), .result_ROB_c3(rob_in[3]),
        .result_FU_c1(fu_in[1]), .result_FU_c2(fu_in[2]), .result_FU_c3(fu_in[3]),
        .update_rob(upd), .rob_p_reg_1(preg1), .rob_p_reg_2(preg2),
        .rob_opcode_1(op1), .rob_opcode_2(op2),
        .o_rob_p_reg_1(old1), .o_rob_p_reg_2(old2), .pd_1_ci(pd),
        .forward_flag_1(ff_o[1]), .forward_flag_2(ff_o[2]), .forward_flag_3(ff_o[3]),
        .dest_R_1(dr_o[1]), .dest_R_2(dr_o[2]), .dest_R_3(dr_o[3]),
        .forwarded_data_1(fd_o[1]), .forwarded_data_2(fd_o[2]), .forwarded_data_3(fd_o[3]),
        .retire_flag_1(rf_o[1]), .retire_flag_2(rf_o[2]),
        .retire_index_1(ri_o[1]), .retire_index_2(ri_o[2]),
        .retire_result_1(rr_o[1]), .retire_result_2(rr_o[2]),
        .fp_ind_1(fp_o[1]), .fp_ind_2(fp_o[2]),
        .pr_flag(pr_o)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic             en_co;
        logic [3:1]       ff;
        logic [3:1][5:0]  dr;
        logic [3:1][31:0] fd;
        logic [2:1]       rf;
        logic [2:1][5:0]  ri;
        logic [2:1][31:0] rr;
        logic [2:1][5:0]  fp;
        logic             pr;
    } out_t;

    typedef struct {
        logic [5:0]  preg;
        logic [5:0]  old;
        logic        st;
        logic        comp;
        logic [31:0] res;
    } m_ent_t;

    out_t             exp_q [$];
    m_ent_t           mq [$];     // in-flight instructions, oldest first
    int               m_head;     // ROB index of mq[0]
    logic [3:1][5:0]  m_dr;
    logic [3:1][31:0] m_fd;

    int checks   = 0;
    int failures = 0;

    // Predict the outputs after the coming edge and advance the model
    task automatic model_step();
        out_t e;
        int   nret;
        int   cnt0;
        int   acc;
        int   pos;
        e = '0;
        if (!rst_n) begin
            mq.delete();
            m_head = 0;
            m_dr   = '0;
            m_fd   = '0;
            exp_q.push_back(e);
            return;
        end
        e.en_co = en_ci;
`ifdef COMPLETE_FORWARD_EN
        for (int k = 1; k <= 3; k++) begin
            if (vld_in[k]) begin
                e.ff[k] = 1'b1;
                m_dr[k] = dst_in[k];
                m_fd[k] = res_in[k];
            end
        end
        e.dr = m_dr;
        e.fd = m_fd;
`endif
        nret = 0;
        if (mq.size() > 0 && mq[0].comp) nret = 1;
        if (nret == 1 && mq.size() > 1 && mq[1].comp) nret = 2;
        for (int j = 0; j < nret; j++) begin
            if (!mq[j].st) begin
                e.rf[j+1] = 1'b1;
                e.ri[j+1] = mq[j].preg;
                e.rr[j+1] = mq[j].res;
                e.fp[j+1] = mq[j].old;
            end
        end
        // lowest channel number applied last so it wins
        for (int k = 3; k >= 1; k--) begin
            if (vld_in[k]) begin
                pos = (int'(rob_in[k]) - m_head + 16) % 16;
                if (pos < mq.size()) begin
                    mq[pos].comp = 1'b1;
                    mq[pos].res  = res_in[k];
                end
            end
        end
        cnt0 = mq.size();
        for (int j = 0; j < nret; j++) mq.delete(0);
        m_head = (m_head + nret) % 16;
        acc = 0;
        if (upd) begin
            if (op1 != 7'd0 && cnt0 + acc < 16) begin
                mq.push_back('{preg: preg1, old: old1, st: (op1 == OP_ST), comp: 1'b0, res: 32'd0});
                acc++;
            end
            if (op2 != 7'd0 && cnt0 + acc < 16) begin
                mq.push_back('{preg: preg2, old: old2, st: (op2 == OP_ST), comp: 1'b0, res: 32'd0});
                acc++;
            end
        end
        e.pr = (nret > 0) && (mq.size() == 0) && !en_ci;
        exp_q.push_back(e);
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    out_t mon_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("en_flag_co", 32'(en_co), 32'(mon_e.en_co));
            for (int k = 1; k <= 3; k++) begin
                check($sformatf("forward_flag_%0d", k), 32'(ff_o[k]), 32'(mon_e.ff[k]));
                check($sformatf("dest_R_%0d", k), 32'(dr_o[k]), 32'(mon_e.dr[k]));
                check($sformatf("forwarded_data_%0d", k), fd_o[k], mon_e.fd[k]);
            end
            for (int j = 1; j <= 2; j++) begin
                check($sformatf("retire_flag_%0d", j), 32'(rf_o[j]), 32'(mon_e.rf[j]));
                check($sformatf("retire_index_%0d", j), 32'(ri_o[j]), 32'(mon_e.ri[j]));
                check($sformatf("retire_result_%0d", j), rr_o[j], mon_e.rr[j]);
                check($sformatf("fp_ind_%0d", j), 32'(fp_o[j]), 32'(mon_e.fp[j]));
            end
            check("pr_flag", 32'(pr_o), 32'(mon_e.pr));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        for (int k = 1; k <= 3; k++) begin
            vld_in[k] = 1'b0;
            res_in[k] = $urandom;
            dst_in[k] = 6'($urandom_range(0, 63));
            rob_in[k] = 4'($urandom_range(0, 15));
            fu_in[k]  = 2'($urandom_range(0, 3));
        end
        upd   = 1'b0;
        op1   = 7'd0;
        op2   = 7'd0;
        preg1 = 6'($urandom_range(0, 63));
        preg2 = 6'($urandom_range(0, 63));
        old1  = 6'($urandom_range(0, 63));
        old2  = 6'($urandom_range(0, 63));
        pd    = 6'($urandom_range(0, 63));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic alloc2(input logic [6:0] a_op1, input logic [5:0] a_p1, input logic [5:0] a_o1,
                          input logic [6:0] a_op2, input logic [5:0] a_p2, input logic [5:0] a_o2);
        upd   = 1'b1;
        op1   = a_op1;
        preg1 = a_p1;
        old1  = a_o1;
        op2   = a_op2;
        preg2 = a_p2;
        old2  = a_o2;
    endtask

    task automatic comp(input int k, input logic [3:0] idx, input logic [31:0] d, input logic [5:0] dst);
        vld_in[k] = 1'b1;
        rob_in[k] = idx;
        res_in[k] = d;
        dst_in[k] = dst;
    endtask

    function automatic logic [6:0] pick_op();
        case ($urandom_range(0, 3))
            0:       return 7'd0;
            1:       return OP_ALU;
            2:       return OP_ST;
            default: return OP_IMM;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int pos;
        clear_inputs();
        rst_n = 1'b0;
        en_ci = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        repeat (3) step();           // idle: no retirement, so no drain pulse

        // two ALU ops completed together, retire together
        en_ci = 1'b1;
        alloc2(OP_ALU, 6'd33, 6'd3, OP_ALU, 6'd34, 6'd4);   // ROB 0,1
        step();
        comp(1, 4'd0, 32'd5, 6'd33);
        comp(2, 4'd1, 32'd7, 6'd34);
        step();
        step();
        step();

        // younger completes first: nothing retires until the older one completes
        alloc2(OP_ALU, 6'd40, 6'd10, OP_ALU, 6'd41, 6'd11); // ROB 2,3
        step();
        comp(1, 4'd3, 32'd99, 6'd41);
        step();
        step();
        comp(3, 4'd2, 32'd88, 6'd40);
        step();
        step();

        // store at head retires silently, then the ALU op behind it
        alloc2(OP_ST, 6'd42, 6'd12, OP_ALU, 6'd43, 6'd13);  // ROB 4,5
        step();
        comp(1, 4'd4, 32'd22, 6'd42);
        comp(3, 4'd9, 32'hdead, 6'd1);                        // entry 9 not valid: ignored
        step();
        comp(1, 4'd5, 32'd11, 6'd43);
        comp(2, 4'd5, 32'd77, 6'd2);                          // same entry: channel 1 wins
        en_ci = 1'b0;
        step();
        step();
        step();

        // reset with an entry in flight, then fill to 16 and run across the wrap
        en_ci = 1'b1;
        alloc2(OP_ALU, 6'd50, 6'd20, 7'd0, 6'd0, 6'd0);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            alloc2(OP_ALU, 6'(8 + 2*i), 6'(2*i), OP_IMM, 6'(9 + 2*i), 6'(2*i + 1));
            step();
        end
        alloc2(OP_ALU, 6'd60, 6'd61, OP_ALU, 6'd62, 6'd63);  // full: dropped
        step();
        comp(1, 4'd0, 32'h100, 6'd8);
        comp(2, 4'd1, 32'h101, 6'd9);
        comp(3, 4'd2, 32'h102, 6'd10);
        step();
        comp(1, 4'd3, 32'h103, 6'd11);
        step();
        step();
        alloc2(OP_ALU, 6'd44, 6'd24, OP_ST, 6'd45, 6'd25);   // ROB 0,1 (wrapped)
        step();
        alloc2(OP_IMM, 6'd46, 6'd26, OP_ALU, 6'd47, 6'd27);  // ROB 2,3
        step();
        for (int g = 0; g < 16; g += 3) begin
            for (int k = 1; k <= 3; k++) begin
                if (g + k - 1 < 16) comp(k, 4'((4 + g + k - 1) % 16), $urandom, 6'(g + k));
            end
            step();
        end
        en_ci = 1'b0;
        repeat (10) step();          // drain: one pr_flag pulse

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 399) != 0);
            en_ci = ($urandom_range(0, 9) != 0);
            if ((c % 500) < 440 && $urandom_range(0, 2) != 0) begin
                op1 = pick_op();
                op2 = pick_op();
                n = int'(op1 != 7'd0) + int'(op2 != 7'd0);
                if (mq.size() + n <= 16) upd = 1'b1;
                else begin
                    op1 = 7'd0;
                    op2 = 7'd0;
                end
            end else if ((c % 500) >= 440) begin
                en_ci = 1'b0;
            end
            for (int k = 1; k <= 3; k++) begin
                if ($urandom_range(0, 2) != 0) begin
                    vld_in[k] = 1'b1;
                    if (mq.size() > 0 && $urandom_range(0, 7) != 0) begin
                        pos = $urandom_range(0, mq.size() - 1);
                        rob_in[k] = 4'((m_head + pos) % 16);
                    end
                end
            end
            if ($urandom_range(0, 7) == 0) rob_in[2] = rob_in[1];
            step();
        end
        rst_n = 1'b1;
        en_ci = 1'b0;
        repeat (20) step();

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
